// File: rtl/key_codes_pkg.sv
// key_codes_pkg: PS/2 scancode constants, channel FSM states and a priority helper
package key_codes_pkg;
  localparam logic [8:0] KEY_UP    = 9'h075;
  localparam logic [8:0] KEY_DOWN  = 9'h072;
  localparam logic [8:0] KEY_LEFT  = 9'h06B;
  localparam logic [8:0] KEY_RIGHT = 9'h074;
  localparam logic [8:0] KEY_Z     = 9'h01A;
  localparam logic [8:0] LSHIFT    = 9'h012;
  localparam logic [8:0] RSHIFT    = 9'h059;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } ch_state_e;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = 4'd0;
    for (int k = 15; k >= 0; k--) if (v[k]) lowest_idx = 4'(k);
  endfunction
endpackage

// File: rtl/key_channel.sv
// key_channel: one decoded key - held level, press/release pulses and typematic repeat
module key_channel
  import key_codes_pkg::*;
#(
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_i,
  input  logic key_i,
  output logic held_nx_o,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic held_q, held_d, press_q, rel_q, rpt_q, rpt_d, rise, fall;
  ch_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign held_d = sample_i ? key_i : held_q;
  assign rise   = held_d & ~held_q;
  assign fall   = ~held_d & held_q;

  // A fall always wins so no repeat pulse can coincide with the release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = 1'b0;
    if (fall) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (rise && REPEAT_EN) begin
      state_d = DELAY;
      cnt_d   = '0;
    end else if (state_q == DELAY) begin
      rpt_d   = (cnt_q == DLY_LAST);
      state_d = rpt_d ? RPT : DELAY;
      cnt_d   = rpt_d ? '0 : cnt_q + 1'b1;
    end else if (state_q == RPT) begin
      rpt_d = (cnt_q == PER_LAST);
      cnt_d = rpt_d ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      held_q  <= held_d;
      press_q <= rise;
      rel_q   <= fall;
      rpt_q   <= rpt_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_nx_o = held_d;
  assign held_o    = held_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign repeat_o  = rpt_q;
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: maps configured scancodes to per-channel key events and tracks the last held key
module key_event_decoder
  import key_codes_pkg::*;
#(
  parameter int                      NUM_KEYS      = 4,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES     = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP},
  parameter bit                      REPEAT_EN     = 1'b1,
  parameter int                      REPEAT_DELAY  = 25_000_000,
  parameter int                      REPEAT_PERIOD = 5_000_000,
  parameter int                      CNT_W         = 25,
  localparam int                     LW            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                been_ready_i,
  input  logic [8:0]          last_change_i,
  input  logic [511:0]        key_down_i,
  output logic [NUM_KEYS-1:0] held_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] repeat_p_o,
  output logic [LW-1:0]       last_key_o,
  output logic                last_valid_o
);
  logic [NUM_KEYS-1:0] held_nx, rise, fall;
  logic [3:0] rise_idx, held_idx;
  logic [LW-1:0] last_key_q, last_key_d;
  logic last_valid_q, last_valid_d, unused_ok;

  // Every channel resamples on each strobe, so a lost break code self-heals
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    localparam logic [8:0] CODE = KEY_CODES[9*i +: 9];
    key_channel #(
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sample_i (been_ready_i),
      .key_i    (key_down_i[CODE]),
      .held_nx_o(held_nx[i]),
      .held_o   (held_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .repeat_o (repeat_p_o[i])
    );
  end

  assign rise     = held_nx & ~held_o;
  assign fall     = ~held_nx & held_o;
  assign rise_idx = lowest_idx(16'(rise));
  assign held_idx = lowest_idx(16'(held_nx));

  always_comb begin
    last_key_d   = last_key_q;
    last_valid_d = last_valid_q;
    if (|rise) begin
      last_key_d   = rise_idx[LW-1:0];
      last_valid_d = 1'b1;
    end else if (last_valid_q && fall[last_key_q]) begin
      last_key_d   = |held_nx ? held_idx[LW-1:0] : last_key_q;
      last_valid_d = |held_nx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_key_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_key_q   <= last_key_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign last_key_o   = last_key_q;
  assign last_valid_o = last_valid_q;
  assign unused_ok    = ^{key_down_i, last_change_i, rise_idx, held_idx};
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed plus random stimulus against a timeline-based reference model
module tb_key_event_decoder;
  import key_codes_pkg::*;
  localparam int N = 4, DLY = 8, PER = 4;
  localparam logic [8:0] CODES [N] = '{KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};

  logic clk = 1'b0, rst_n = 1'b0, br = 1'b0;
  logic [8:0] lc = '0;
  logic [511:0] kd = '0;
  logic [N-1:0] held, press, rel, rpt;
  logic [1:0] lk;
  logic lv;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  key_event_decoder #(.NUM_KEYS(N), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .been_ready_i(br), .last_change_i(lc), .key_down_i(kd),
    .held_o(held), .press_o(press), .release_o(rel), .repeat_p_o(rpt),
    .last_key_o(lk), .last_valid_o(lv)
  );

  // Reference: repeats are derived from the cycle number of the press, not a counter FSM
  logic [N-1:0] e_held, e_press, e_rel, e_rpt, m_nh, m_pr, m_rl, m_rp;
  logic [1:0] e_lk;
  logic e_lv;
  int cyc;
  int pc [N];

  function automatic int lowest(input logic [N-1:0] v);
    lowest = 0;
    for (int k = N - 1; k >= 0; k--) if (v[k]) lowest = k;
  endfunction

  always_comb begin
    m_nh = e_held;
    m_rp = '0;
    if (br) for (int i = 0; i < N; i++) m_nh[i] = kd[CODES[i]];
    m_pr = m_nh & ~e_held;
    m_rl = ~m_nh & e_held;
    for (int i = 0; i < N; i++)
      if (m_nh[i] && !m_pr[i] && (cyc + 1 - pc[i]) >= DLY && ((cyc + 1 - pc[i] - DLY) % PER) == 0)
        m_rp[i] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_held <= '0; e_press <= '0; e_rel <= '0; e_rpt <= '0;
      e_lk <= '0; e_lv <= 1'b0; cyc <= 0;
      for (int i = 0; i < N; i++) pc[i] <= 0;
    end else begin
      e_held <= m_nh; e_press <= m_pr; e_rel <= m_rl; e_rpt <= m_rp;
      for (int i = 0; i < N; i++) if (m_pr[i]) pc[i] <= cyc + 1;
      if (|m_pr) begin
        e_lk <= 2'(lowest(m_pr));
        e_lv <= 1'b1;
      end else if (e_lv && m_rl[e_lk]) begin
        if (|m_nh) e_lk <= 2'(lowest(m_nh));
        else e_lv <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("held", 32'(held), 32'(e_held));
    chk("press", 32'(press), 32'(e_press));
    chk("release", 32'(rel), 32'(e_rel));
    chk("repeat", 32'(rpt), 32'(e_rpt));
    chk("last_valid", 32'(lv), 32'(e_lv));
    chk("last_key", 32'(lk), 32'(e_lk));
  end

  task automatic strobe(input logic [8:0] code);
    lc = code;
    br = 1'b1;
    @(negedge clk);
    br = 1'b0;
  endtask

  task automatic key(input logic [8:0] code, input logic dn);
    kd[code] = dn;
    strobe(code);
  endtask

  logic [8:0] pool [8];
  logic [8:0] c;

  initial begin
    pool = '{KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_Z, LSHIFT, RSHIFT, 9'h000};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_outputs", 32'({held, press, rel, rpt, lv}), 0);
    key(KEY_UP, 1'b1);
    chk("up_held", 32'(held), 32'h1);
    chk("up_press", 32'(press), 32'h1);
    repeat (7) @(negedge clk);
    chk("no_early_rpt", 32'(rpt), 0);
    @(negedge clk);
    chk("rpt_t9", 32'(rpt), 32'h1);
    repeat (4) @(negedge clk);
    chk("rpt_t13", 32'(rpt), 32'h1);
    repeat (4) @(negedge clk);
    chk("rpt_t17", 32'(rpt), 32'h1);
    @(negedge clk);
    key(KEY_UP, 1'b0);
    chk("up_release", 32'(rel), 32'h1);
    chk("up_held_low", 32'(held), 0);
    repeat (10) @(negedge clk);
    chk("no_rpt_after_rel", 32'(rpt), 0);
    key(KEY_LEFT, 1'b1);
    chk("lk_left", 32'({lv, lk}), 32'h6);
    repeat (3) @(negedge clk);
    key(KEY_UP, 1'b1);
    chk("lk_up", 32'({lv, lk}), 32'h4);
    repeat (3) @(negedge clk);
    key(KEY_UP, 1'b0);
    chk("lk_back_left", 32'({lv, lk}), 32'h6);
    key(KEY_LEFT, 1'b0);
    chk("lk_invalid", 32'(lv), 0);
    key(KEY_RIGHT, 1'b1);
    repeat (2) @(negedge clk);
    kd[KEY_RIGHT] = 1'b0;
    kd[KEY_Z] = 1'b1;
    strobe(KEY_Z);
    chk("missed_break_held", 32'(held), 0);
    chk("missed_break_rel", 32'(rel), 32'h8);
    kd[KEY_Z] = 1'b0;
    strobe(KEY_Z);
    kd[KEY_DOWN] = 1'b1;
    kd[KEY_RIGHT] = 1'b1;
    strobe(KEY_RIGHT);
    chk("dual_press", 32'(press), 32'hA);
    chk("dual_lk", 32'({lv, lk}), 32'h5);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_held", 32'(held), 0);
    chk("async_rst_pulses", 32'({press, rel, rpt, lv}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_quiet", 32'({held, rpt}), 0);
    strobe(KEY_Z);
    chk("fresh_press", 32'(press), 32'hA);
    repeat (8) @(negedge clk);
    chk("fresh_rpt", 32'(rpt), 32'hA);
    kd = '0;
    strobe(KEY_Z);
    chk("fresh_release", 32'(rel), 32'hA);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) kd[CODES[$urandom_range(0, N - 1)]] = 1'(~kd[CODES[$urandom_range(0, N - 1)]]);
      if ($urandom_range(0, 2) == 0) begin
        c = pool[$urandom_range(0, 7)];
        if (c == 9'h000) c = 9'($urandom);
        kd[c] = 1'($urandom_range(0, 1));
        strobe(c);
      end else @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Parametrised successor to the four-direction key decoder.
- Maps NUM_KEYS configurable PS/2 scancodes onto per-channel held levels, one-cycle press/release pulses and typematic auto-repeat pulses.
- Also tracks the most recently pressed key that is still held.
- Sits between the keyboard receiver (been_ready, last_change, key_down) and game/control logic.

Parameters:
- NUM_KEYS, 4: number of decoded channels (1..16).
- KEY_CODES, {9'h075,9'h072,9'h06B,9'h074}: packed NUM_KEYS x 9-bit scancodes; channel i = KEY_CODES[9*i+8:9*i]. Default order is ch0=UP, ch1=DOWN, ch2=LEFT, ch3=RIGHT.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 forces repeat_p to 0.
- REPEAT_DELAY, 25_000_000: cycles from press to the first repeat pulse (at least 2).
- REPEAT_PERIOD, 5_000_000: cycles between later repeat pulses (at least 2).
- CNT_W, 25: repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD)-1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-low.
- been_ready, in, 1: one-cycle strobe; last_change and key_down are valid in this cycle.
- last_change, in, 9: scancode of the latest make/break event.
- key_down, in, 512: current pressed bitmap indexed by scancode.
- held, out, NUM_KEYS: registered pressed level per channel.
- press, out, NUM_KEYS: one-cycle pulse when held rises.
- release, out, NUM_KEYS: one-cycle pulse when held falls.
- repeat_p, out, NUM_KEYS: one-cycle auto-repeat pulse.
- last_key, out, max(1,$clog2(NUM_KEYS)): index of the most recent pressed channel still held.
- last_valid, out, 1: last_key is meaningful.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all channel FSMs IDLE, counters 0.
- Held update:
  - On a cycle with been_ready=1, every channel samples held_next[i] = key_down[code_i], not only the channel matching last_change. This resyncs any missed break code.
  - With been_ready=0, held is unchanged.
  - held is registered, so it changes one cycle after the been_ready cycle.
- Press/release: press[i] = 1 in exactly the cycle held[i] goes 0 to 1; release[i] = 1 in exactly the cycle held[i] goes 1 to 0. Both are registered alongside held and are never asserted together.
- Per-channel FSM (IDLE, DELAY, RPT), with counter cnt:
  - IDLE: on a held rise, go to DELAY with cnt=0.
  - DELAY: cnt increments each cycle. At cnt==REPEAT_DELAY-1, pulse repeat_p[i], set cnt=0, go to RPT.
  - RPT: cnt increments each cycle. At cnt==REPEAT_PERIOD-1, pulse repeat_p[i] and set cnt=0.
  - A held fall in any state: go to IDLE, cnt=0, and no repeat_p in that cycle.
  - REPEAT_EN=0: the FSM stays in IDLE.
- Repeat timing: the first repeat_p comes REPEAT_DELAY cycles after the press pulse; subsequent pulses are REPEAT_PERIOD apart.
- Tracking of last_key:
  - Any press: last_key is set to the pressed index and last_valid=1. If several channels press in the same cycle, the lowest index wins.
  - Release of the channel equal to last_key, with no press that cycle:
    - If any other channel is still held, last_key becomes the lowest held index.
    - Otherwise last_valid=0 and last_key is unchanged.
  - A press and a release in the same cycle: the press rule wins.
- Unmatched scancodes: no effect, apart from the resync of all channels on that been_ready.
- Duplicate KEY_CODES entries: both channels behave identically.
- Reset asserted mid-repeat: clears at once; no spurious pulse after reset deasserts.

Decomposition:
- Package key_codes_pkg:
  - Scancode constants KEY_UP=9'h075, KEY_DOWN=9'h072, KEY_LEFT=9'h06B, KEY_RIGHT=9'h074, KEY_Z=9'h01A, LSHIFT=9'h012, RSHIFT=9'h059.
  - FSM state encoding (IDLE=2'd0, DELAY=2'd1, RPT=2'd2).
- Sub-module key_channel: one held/press/release/repeat FSM per channel, instantiated NUM_KEYS times in a generate loop.
- The top level holds the scancode lookup and the last_key priority logic.

Test Plan:
- Reset then idle, REPEAT_DELAY=8, REPEAT_PERIOD=4 -> all outputs 0 for 20 cycles.
- been_ready with last_change=9'h075 and key_down[9'h075]=1 at cycle t -> held[0]=1 and press[0]=1 at t+1; repeat_p[0] at t+9, t+13, t+17. Break at t+18 -> release[0] at t+19 and no further repeats.
- Press LEFT then UP, then release UP -> last_key=2, then 0, then back to 2 with last_valid=1. Release LEFT -> last_valid=0.
- Missed break: key_down[9'h074] cleared while last_change=9'h01A -> held[3] falls and release[3] pulses on that event.
- Two codes set in key_down in one been_ready (ch1 and ch3) -> both press pulses; last_key=1.
- Drive rst=0 asynchronously between clock edges while in RPT -> outputs clear immediately; after rst=1 the first repeat_p needs a fresh press.
